// File: rtl/image_streamer.sv
// image_streamer: holds one image in a host-writable buffer and, on start,
// streams it pixel by pixel into the classifier core, then waits (bounded by
// TIMEOUT) for the core's digit and reports it with a one-cycle done pulse.
module image_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PIXELS  = 784,
  parameter int DIGIT_WIDTH = 4,
  parameter int TIMEOUT     = 4096,
  parameter int ADDR_W      = $clog2(NUM_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [DIGIT_WIDTH-1:0] result,
  output logic                   i_valid,
  output logic [DATA_WIDTH-1:0]  pixel,
  input  logic                   o_valid,
  input  logic [DIGIT_WIDTH-1:0] digit
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   mem [NUM_PIXELS];
  logic [ADDR_W-1:0]       rd_addr;
  logic [TCNT_W-1:0]       tcnt;
  logic                    idle_like;
  logic                    accept;
  logic                    finish_ok;
  logic                    finish_to;
  logic                    wr_ok;

  // Next-state decode: start in IDLE/DONE, leave STREAM after the last read
  // issue, leave WAIT on a result (which beats a coincident timeout).
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    idle_like = (state == S_IDLE) || (state == S_DONE);
    wr_ok     = wr_en && idle_like && (wr_addr <= LAST_ADDR);
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_addr == LAST_ADDR) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (o_valid) begin
          finish_ok = 1'b1;
          state_nxt = S_DONE;
        end else if (tcnt == TCNT_LAST) begin
          finish_to = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Host write port into the image buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // State, read pointer, timeout counter and all registered outputs.
  // pixel is the buffer's synchronous read register, so a read issued in a
  // STREAM cycle is presented with i_valid in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      tcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
      i_valid <= 1'b0;
      pixel   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      if (state == S_STREAM) begin
        pixel   <= mem[rd_addr];
        i_valid <= 1'b1;
      end else begin
        pixel   <= '0;
        i_valid <= 1'b0;
      end

      if (accept) begin
        busy    <= 1'b1;
        error   <= 1'b0;
        rd_addr <= '0;
      end else if ((state == S_STREAM) && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + 1'b1;
      end

      // Counts cycles since the last pixel was presented, so the timeout
      // done pulse lands exactly TIMEOUT cycles after that pixel.
      if (state != S_WAIT) begin
        tcnt <= '0;
      end else if (tcnt != '1) begin
        tcnt <= tcnt + 1'b1;
      end

      if (finish_ok) result <= digit;
      if (finish_to) error  <= 1'b1;
      if (finish_ok || finish_to) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// Testbench for image_streamer: scenario tasks drive a host and a core model,
// and check the streamed pixels and the result handshake against an array
// model of the buffer and cycle arithmetic derived from the start cycle.
module tb_image_streamer;

  localparam int DW = 8;
  localparam int N  = 784;
  localparam int GW = 4;
  localparam int TO = 4096;
  localparam int AW = $clog2(N);

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start   = 1'b0;
  logic          o_valid = 1'b0;
  logic [GW-1:0] digit   = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [GW-1:0] result;
  logic          i_valid;
  logic [DW-1:0] pixel;

  image_streamer #(
    .DATA_WIDTH (DW),
    .NUM_PIXELS (N),
    .DIGIT_WIDTH(GW),
    .TIMEOUT    (TO),
    .ADDR_W     (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result),
    .i_valid(i_valid),
    .pixel  (pixel),
    .o_valid(o_valid),
    .digit  (digit)
  );

  always #5 clk = ~clk;

  // cyc is the number of the clock period currently in progress.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents and last reported digit.
  logic [DW-1:0] ref_mem [N];
  logic [GW-1:0] ref_result;

  // Observation queues filled by the monitor.
  logic [DW-1:0] pix_q[$];
  int            pcyc_q[$];
  int            done_q[$];
  int            busy_gap = 0;
  int            done_busy_bad = 0;
  logic          prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (i_valid) begin
        pix_q.push_back(pixel);
        pcyc_q.push_back(cyc);
        if (!busy) busy_gap++;
      end
      if (done) begin
        done_q.push_back(cyc);
        if (busy || !prev_busy) done_busy_bad++;
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  // Number of beats disagreeing with a stream that started at cycle k.
  function automatic int stream_bad(input int k);
    int bad = 0;
    if (pix_q.size() != N) bad++;
    for (int i = 0; i < pix_q.size() && i < N; i++) begin
      if (pcyc_q[i] != k + 2 + i || pix_q[i] !== ref_mem[i]) bad++;
    end
    return bad;
  endfunction

  task automatic clear_mon();
    pix_q.delete();
    pcyc_q.delete();
    done_q.delete();
    busy_gap = 0;
    done_busy_bad = 0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_buffer(input bit ramp);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = ramp ? DW'(i % 256) : DW'($urandom);
      ref_mem[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // start is high for the whole of cycle k; returns one cycle later.
  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Core model answer: o_valid high for the whole of cycle c.
  task automatic pulse_ovalid(input int c, input logic [GW-1:0] dg);
    wait_cyc(c);
    o_valid = 1'b1;
    digit   = dg;
    @(negedge clk);
    o_valid = 1'b0;
    digit   = GW'($urandom);
  endtask

  task automatic test_reset();
    logic [2*GW+DW+4-1:0] outs;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    outs = {busy, done, error, i_valid, pixel, result};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs %h, required 0", outs);
    end
    rst = 1'b1;
    ref_result = '0;
    repeat (3) @(negedge clk);
    outs = {busy, done, error, i_valid, pixel, result};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs %h, required 0", outs);
    end
  endtask

  task automatic test_stream_result();
    int k, l, bad;
    load_buffer(1'b1);
    clear_mon();
    pulse_start(k);
    l = k + 1 + N;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy %b, required 1", busy);
    end
    pulse_ovalid(l + 10, 4'd7);
    ref_result = 4'd7;
    checks++;
    if ({done, error, busy, result} !== {1'b1, 1'b0, 1'b0, ref_result}) begin
      errors++;
      $display("FAIL result_done: done/error/busy/result %b/%b/%b/%0d, required 1/0/0/%0d",
               done, error, busy, result, ref_result);
    end
    pulse_ovalid(l + 14, 4'd2);
    wait_cyc(l + 18);
    bad = stream_bad(k);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stream_ramp: %0d bad beats (beats %0d, required %0d)", bad, pix_q.size(), N);
    end
    checks++;
    if (busy_gap !== 0) begin
      errors++;
      $display("FAIL busy_during_stream: %0d valid beats with busy low, required 0", busy_gap);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != l + 11) begin
      errors++;
      $display("FAIL done_pulse: %0d pulses first at %0d, required 1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, l + 11);
    end
    checks++;
    if (done_busy_bad !== 0 || result !== ref_result) begin
      errors++;
      $display("FAIL done_busy_idle_ovalid: busy-edge errors %0d result %0d, required 0 and %0d",
               done_busy_bad, result, ref_result);
    end
  endtask

  task automatic test_timeout();
    int k, l, bad;
    clear_mon();
    pulse_start(k);
    l = k + 1 + N;
    wait_cyc(l + TO - 1);
    checks++;
    if ({done, error} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_early: done/error %b/%b at %0d, required 0/0", done, error, cyc);
    end
    wait_cyc(l + TO);
    checks++;
    if ({done, error, busy, result} !== {1'b1, 1'b1, 1'b0, ref_result}) begin
      errors++;
      $display("FAIL timeout_done: done/error/busy/result %b/%b/%b/%0d, required 1/1/0/%0d",
               done, error, busy, result, ref_result);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_q.size() != 1 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: pulses %0d error %b, required 1 and 1", done_q.size(), error);
    end
    bad = stream_bad(k);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stream_timeout: %0d bad beats, required 0", bad);
    end
  endtask

  task automatic test_busy_ignore();
    int k, l, d, bad;
    logic [GW-1:0] dg;
    logic [DW-1:0] got5;
    load_buffer(1'b0);
    clear_mon();
    pulse_start(k);
    l = k + 1 + N;
    checks++;
    if ({busy, error} !== 2'b10) begin
      errors++;
      $display("FAIL error_clear: busy/error %b/%b, required 1/0", busy, error);
    end
    wait_cyc(k + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(k + 100);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = ~ref_mem[5];
    @(negedge clk);
    wr_en = 1'b0;
    pulse_ovalid(k + 200, ref_result + 4'd3);
    wait_cyc(k + 210);
    checks++;
    if (result !== ref_result) begin
      errors++;
      $display("FAIL ovalid_stream_ignored: result %0d, required %0d", result, ref_result);
    end
    wait_cyc(l + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d  = $urandom_range(5, 40);
    dg = GW'($urandom);
    pulse_ovalid(l + d, dg);
    ref_result = dg;
    checks++;
    if ({done, error, result} !== {1'b1, 1'b0, ref_result}) begin
      errors++;
      $display("FAIL busy_run_result: done/error/result %b/%b/%0d, required 1/0/%0d", done, error, result, ref_result);
    end
    repeat (3) @(negedge clk);
    bad = stream_bad(k);
    checks++;
    if (bad !== 0 || done_q.size() != 1) begin
      errors++;
      $display("FAIL no_restart: %0d bad beats, %0d done pulses, required 0 and 1", bad, done_q.size());
    end
    clear_mon();
    pulse_start(k);
    l = k + 1 + N;
    d  = $urandom_range(1, 40);
    dg = GW'($urandom);
    pulse_ovalid(l + d, dg);
    ref_result = dg;
    repeat (3) @(negedge clk);
    got5 = (pix_q.size() > 5) ? pix_q[5] : 'x;
    checks++;
    if (got5 !== ref_mem[5]) begin
      errors++;
      $display("FAIL busy_write_ignored: pixel5 %h, required %h", got5, ref_mem[5]);
    end
    bad = stream_bad(k);
    checks++;
    if (bad !== 0 || result !== ref_result) begin
      errors++;
      $display("FAIL rerun: %0d bad beats result %0d, required 0 and %0d", bad, result, ref_result);
    end
  endtask

  task automatic test_reset_midstream();
    int k, l, d, bad;
    logic [GW-1:0] dg;
    clear_mon();
    pulse_start(k);
    wait_cyc(k + 302);
    rst = 1'b0;
    #1;
    checks++;
    if ({i_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_midstream: i_valid/busy %b/%b, required 0/0", i_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    ref_result = '0;
    @(negedge clk);
    checks++;
    if ({done, error, i_valid, result} !== {3'b000, ref_result}) begin
      errors++;
      $display("FAIL reset_midstream_state: done/error/i_valid/result %b/%b/%b/%0d, required 0/0/0/0",
               done, error, i_valid, result);
    end
    clear_mon();
    pulse_start(k);
    l = k + 1 + N;
    d  = $urandom_range(1, 40);
    dg = GW'($urandom);
    pulse_ovalid(l + d, dg);
    ref_result = dg;
    repeat (3) @(negedge clk);
    bad = stream_bad(k);
    checks++;
    if (bad !== 0 || result !== ref_result) begin
      errors++;
      $display("FAIL restream_after_reset: %0d bad beats result %0d, required 0 and %0d", bad, result, ref_result);
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2, l1, l2, d, dd, bad;
    logic [GW-1:0] x1, x2;
    clear_mon();
    pulse_start(k1);
    l1 = k1 + 1 + N;
    wait_cyc(l1 + 1);
    bad = stream_bad(k1);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_first_stream: %0d bad beats, required 0", bad);
    end
    clear_mon();
    d  = $urandom_range(3, 30);
    x1 = GW'($urandom);
    pulse_ovalid(l1 + d, x1);
    dd = cyc;
    checks++;
    if ({done, result} !== {1'b1, x1} || dd != l1 + d + 1) begin
      errors++;
      $display("FAIL b2b_first_done: done/result %b/%0d at %0d, required 1/%0d at %0d",
               done, result, dd, x1, l1 + d + 1);
    end
    start = 1'b1;
    k2 = cyc;
    @(negedge clk);
    start = 1'b0;
    l2 = k2 + 1 + N;
    x2 = x1 ^ GW'($urandom_range(1, 15));
    pulse_ovalid(l2 + TO - 1, x2);
    ref_result = x2;
    checks++;
    if ({done, error, result} !== {1'b1, 1'b0, ref_result}) begin
      errors++;
      $display("FAIL ovalid_beats_timeout: done/error/result %b/%b/%0d, required 1/0/%0d",
               done, error, result, ref_result);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pcyc_q.size() == 0 || pcyc_q[0] != dd + 2) begin
      errors++;
      $display("FAIL b2b_second_begin: first beat at %0d, required %0d",
               (pcyc_q.size() > 0) ? pcyc_q[0] : -1, dd + 2);
    end
    bad = stream_bad(k2);
    checks++;
    if (bad !== 0 || done_q.size() != 2 || done_busy_bad !== 0) begin
      errors++;
      $display("FAIL b2b_second_stream: %0d bad beats, %0d pulses, %0d busy-edge errors, required 0, 2, 0",
               bad, done_q.size(), done_busy_bad);
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream_result();
    test_timeout();
    test_busy_ignore();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
